// File: rtl/uart_tx.sv
// uart_tx: serial transmitter for 5..8 data bits, optional odd/even parity and
// one or two stop bits. A free-running baud square wave is turned into a
// one-clk tick. The frame sequencer then advances one bit per tick.
//
// Handshake: a byte is accepted on any clk edge where tx_valid && tx_ready.
// tx_ready is high only in IDLE. At that edge tx_data is copied into the shift
// register and its parity is computed. While tx_ready is low, tx_valid and
// tx_data are ignored. After acceptance the producer may change them freely.
module uart_tx #(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       baud,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done,
   output logic [2:0] state_dbg
);

   // Frame sequencer states
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ARM    = 3'd1;
   localparam logic [2:0] ST_START  = 3'd2;
   localparam logic [2:0] ST_DATA   = 3'd3;
   localparam logic [2:0] ST_PARITY = 3'd4;
   localparam logic [2:0] ST_STOP   = 3'd5;

   // Only the low DATA_BITS of the byte are sent or enter the parity.
   localparam logic [7:0] DATA_MASK  = 8'((16'd1 << DATA_BITS) - 16'd1);
   // Counter value while the final data bit is on the line.
   localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);
   // Stop counter value while the final stop bit is on the line.
   localparam logic       LAST_STOP  = 1'(STOP_BITS - 1);
   localparam logic       HAS_PARITY = (PARITY != 0);
   // Odd parity is the inverse of the plain XOR of the data bits.
   localparam logic       PAR_INV    = (PARITY == 1);

   logic       baud_q;
   logic       tick;
   logic       accept;
   logic [2:0] state;
   logic [2:0] state_nxt;
   logic [7:0] shift;
   logic [2:0] bit_cnt;
   logic       stop_cnt;
   logic       par_bit;
   logic       last_data;
   logic       last_stop;

   assign tick      = baud & ~baud_q;
   assign tx_ready  = (state == ST_IDLE);
   assign tx_busy   = (state != ST_IDLE);
   assign accept    = tx_valid && tx_ready;
   assign last_data = (bit_cnt == LAST_BIT);
   assign last_stop = (stop_cnt == LAST_STOP);
   assign state_dbg = state;

   // Delayed copy of the baud wave for rising-edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         baud_q <= 1'b0;
      end else begin
         baud_q <= baud;
      end
   end

   // Next-state selection: only IDLE->ARM is independent of tick
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) state_nxt = ST_ARM;
         end
         ST_ARM: begin
            if (tick) state_nxt = ST_START;
         end
         ST_START: begin
            if (tick) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (tick && last_data) state_nxt = HAS_PARITY ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: begin
            if (tick) state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (tick && last_stop) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Shift register, data bit counter and captured parity
   always_ff @(posedge clk) begin
      if (reset) begin
         shift   <= 8'h00;
         bit_cnt <= 3'd0;
         par_bit <= 1'b0;
      end else if (accept) begin
         shift   <= tx_data & DATA_MASK;
         bit_cnt <= 3'd0;
         par_bit <= (^(tx_data & DATA_MASK)) ^ PAR_INV;
      end else if (tick) begin
         case (state)
            ST_START: begin
               shift <= shift >> 1;
            end
            ST_DATA: begin
               // Hold at the last index so the counter never wraps in a frame.
               if (!last_data) begin
                  bit_cnt <= bit_cnt + 3'd1;
                  shift   <= shift >> 1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Stop bit counter, cleared for every new frame
   always_ff @(posedge clk) begin
      if (reset) begin
         stop_cnt <= 1'b0;
      end else if (accept) begin
         stop_cnt <= 1'b0;
      end else if (tick && state == ST_STOP && !last_stop) begin
         stop_cnt <= stop_cnt + 1'b1;
      end
   end

   // Serial line: changes only on tick edges, so each bit lasts one interval
   always_ff @(posedge clk) begin
      if (reset) begin
         tx <= 1'b1;
      end else if (tick) begin
         case (state)
            ST_ARM:    tx <= 1'b0;
            ST_START:  tx <= shift[0];
            ST_DATA: begin
               if (last_data) tx <= HAS_PARITY ? par_bit : 1'b1;
               else           tx <= shift[0];
            end
            ST_PARITY: tx <= 1'b1;
            default:   tx <= 1'b1;
         endcase
      end
   end

   // One-clk pulse as the final stop bit completes
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_done <= 1'b0;
      end else begin
         tx_done <= tick && (state == ST_STOP) && last_stop;
      end
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving data bits per frame (legal 5..8).
REQ-002 The block SHALL have parameter PARITY, default 0, selecting the parity bit: 0 none, 1 odd, 2 even.
REQ-003 The block SHALL have parameter STOP_BITS, default 1, giving stop bits per frame (legal 1 or 2).
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 baud  input  1  square wave from the baud generator; each rising edge marks one bit-period boundary.
REQ-007 tx_data  input  8  byte to send; bits [DATA_BITS-1:0] are used and upper bits are ignored.
REQ-008 tx_valid  input  1  tx_data is valid and a send is requested.
REQ-009 tx_ready  output  1  block can accept a byte; equals (state == IDLE).
REQ-010 tx  output  1  serial line, registered, idle high.
REQ-011 tx_busy  output  1  high whenever state != IDLE.
REQ-012 tx_done  output  1  one-clk pulse when a frame's final stop bit completes.

Function
REQ-013 The block SHALL register baud into baud_q each clk and SHALL form tick = baud & ~baud_q, so tick is one clk wide and lags the baud rising edge by one clk.
REQ-014 Handshake: a byte SHALL be accepted on a clk edge where tx_valid && tx_ready; tx_data is captured into a shift register at that edge, and tx_data and tx_valid are don't-care afterwards.
REQ-015 While tx_ready is low, tx_valid SHALL be ignored and no data SHALL be captured.
REQ-016 States SHALL be IDLE, ARM, START, DATA, PARITY, STOP; except for IDLE->ARM, all transitions occur only on clk edges where tick=1.
REQ-017 IDLE: tx=1; on accept, go to ARM with the bit counter cleared.
REQ-018 ARM: tx=1; on tick, go to START and drive tx=0.
REQ-019 START: on tick, go to DATA, drive tx=shift[0], and shift right.
REQ-020 DATA: on tick, increment the bit counter; after DATA_BITS bits have each been held for one tick interval, go to PARITY (PARITY!=0) or STOP; otherwise drive the next LSB.
REQ-021 Data SHALL be sent LSB first.
REQ-022 PARITY: tx = XOR of the sent data bits (even, PARITY=2) or its inverse (odd, PARITY=1); on tick, go to STOP with tx=1.
REQ-023 The parity value SHALL be computed from the captured byte, not from live tx_data.
REQ-024 STOP: tx=1 for STOP_BITS tick intervals; on the final tick, go to IDLE and pulse tx_done for exactly that one clk.
REQ-025 The tx output SHALL change only on tick edges, apart from reset, so every bit lasts exactly one tick interval.
REQ-026 Back-to-back frames: a byte accepted on the first IDLE cycle after STOP SHALL pass through ARM, giving exactly one idle bit period between frames; that gap is required behaviour.
REQ-027 A tick that coincides with an accept in IDLE SHALL NOT advance the state; the next tick moves ARM->START.
REQ-028 Ticks in IDLE SHALL have no effect.
REQ-029 The bit counter SHALL be 3 bits wide and SHALL never wrap within a frame.

Reset
REQ-030 While reset=1 at a clk edge, the block SHALL set state=IDLE, tx=1, tx_ready=1, tx_busy=0, tx_done=0, baud_q=0, and clear the shift register and counters.
REQ-031 Reset asserted mid-frame SHALL abort the frame: tx=1 from the next clk, and no tx_done is produced for the aborted frame.
REQ-032 The first byte can be accepted on the first clk edge after reset deasserts.

Verification
REQ-033 Drive baud at 16 clk high / 16 low (tick every 32 clk), defaults, send 0x55 -> tx holds 1 (ARM), then 0, 1,0,1,0,1,0,1,0, then 1, each for exactly 32 clk; tx_done pulses once; tx_ready then returns to 1.
REQ-034 PARITY=2, send 0xA5 -> data bits 1,0,1,0,0,1,0,1, parity bit 0; PARITY=1 with the same byte -> parity bit 1.
REQ-035 STOP_BITS=2, DATA_BITS=7, send 0xFF -> start bit, 7 ones, 2 stop bits totalling 64 clk high, and bit 7 is never sent.
REQ-036 Hold tx_valid=1 with tx_data changing every clk during a frame -> the frame content is unchanged and the next byte is captured only on the cycle after tx_done.
REQ-037 Assert reset for 1 clk during DATA bit 3 -> tx=1, tx_busy=0, tx_ready=1 next clk, no tx_done; a new 0x3C sends correctly afterwards.
REQ-038 Assert tx_valid in the same clk as a tick in IDLE -> ARM lasts a full 32 clk before the start bit.
